sw_toggle_ctrl: RTL

Controller that sequences the one-bit toggle state register from a raw, bouncing push-button/switch. It synchronizes and debounces `sw`, runs a press/release state machine, and issues exactly one single-cycle toggle command per accepted press. The held state is output as `q`. It sits between the board switch pin and any logic that consumes the toggled state, replacing direct use of the raw switch as the state-register input.

---
 rtl/sw_toggle_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/sw_toggle_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sw_toggle_pkg.sv
// Shared state encoding, default timing constants and state decode helpers
// for the debounced switch toggle controller.
package sw_toggle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_HELD   = 2'd2,
    ST_DISARM = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_CYCLES   = 64;
  localparam int DEF_CNT_W           = 16;

  function automatic logic f_is_pressed(input state_e s);
    return (s == ST_HELD) || (s == ST_DISARM);
  endfunction

  function automatic logic f_is_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals asynchronous to clk; both
// stages clear to 0 on the asynchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sw_toggle_ctrl.sv
// Debounced push-button toggle controller: one toggle of q per accepted press.
// Optional auto-repeat while held is enabled by defining SW_TOGGLE_AUTO_REPEAT_EN.
module sw_toggle_ctrl
  import sw_toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic q,
  output logic toggle,
  output logic pressed,
  output logic busy
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef SW_TOGGLE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             w_sw_s;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_toggle;
  logic             r_pressed;
  logic             r_busy;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (sw),
    .o_q   (w_sw_s)
  );

  // State, counter, q and decoded outputs; pressed/busy are loaded on each
  // state change from the decode of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_toggle  <= 1'b0;
      r_pressed <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_toggle <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sw_s) begin
            r_state   <= ST_ARM;
            r_cnt     <= '0;
            r_pressed <= f_is_pressed(ST_ARM);
            r_busy    <= f_is_busy(ST_ARM);
          end else begin
            r_cnt <= '0;
          end
        end
        ST_ARM: begin
          if (!w_sw_s) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pressed <= f_is_pressed(ST_IDLE);
            r_busy    <= f_is_busy(ST_IDLE);
          end else if (r_cnt == DB_LAST) begin
            r_state   <= ST_HELD;
            r_cnt     <= '0;
            r_q       <= ~r_q;
            r_toggle  <= 1'b1;
            r_pressed <= f_is_pressed(ST_HELD);
            r_busy    <= f_is_busy(ST_HELD);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!w_sw_s) begin
            r_state   <= ST_DISARM;
            r_cnt     <= '0;
            r_pressed <= f_is_pressed(ST_DISARM);
            r_busy    <= f_is_busy(ST_DISARM);
`ifdef SW_TOGGLE_AUTO_REPEAT_EN
          end else if (r_cnt == RPT_LAST) begin
            r_cnt    <= '0;
            r_q      <= ~r_q;
            r_toggle <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
`else
          end else begin
            r_cnt <= r_cnt;
          end
`endif
        end
        ST_DISARM: begin
          if (w_sw_s) begin
            // Release bounce: back to HELD, any repeat count restarts.
            r_state   <= ST_HELD;
            r_cnt     <= '0;
            r_pressed <= f_is_pressed(ST_HELD);
            r_busy    <= f_is_busy(ST_HELD);
          end else if (r_cnt == DB_LAST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pressed <= f_is_pressed(ST_IDLE);
            r_busy    <= f_is_busy(ST_IDLE);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign q       = r_q;
  assign toggle  = r_toggle;
  assign pressed = r_pressed;
  assign busy    = r_busy;

endmodule
